// File: rtl/program_load_controller.sv
// Arbitrates the program memory port between the UART loader and CPU fetch, holding the core in
// reset until the link has been idle for TIMEOUT_CYCLES. Optional feature macro: LOAD_CHECKSUM_EN.
module program_load_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 20_000_000,
    parameter int unsigned MEM_BYTES      = 4096,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              word_valid,
    input  logic [31:0]       loader_word,
    input  logic [ADDR_W-1:0] loader_addr,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              reload_req,
    output logic [ADDR_W-1:0] mem_byte_address,
    output logic              mem_write_enable,
    output logic [31:0]       mem_write_data,
    output logic              cpu_reset_n,
    output logic              loading,
    output logic              overflow,
    output logic [15:0]       words_loaded
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [31:0]       load_checksum
`endif
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitFirst,
        StLoading,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
    logic              cpu_reset_n_q, cpu_reset_n_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       words_q, words_d;
    logic              in_range;
    logic              in_load;
    logic              accept;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0]       checksum_q, checksum_d;
`endif

    assign in_range = loader_addr < ADDR_W'(MEM_BYTES);
    assign in_load  = (state_q != StRun);
    assign accept   = word_valid & in_load & in_range;

    assign mem_byte_address = in_load ? loader_addr : fetch_addr;
    assign mem_write_data   = loader_word;
    assign mem_write_enable = accept;
    assign cpu_reset_n      = cpu_reset_n_q;
    assign loading          = in_load;
    assign overflow         = overflow_q;
    assign words_loaded     = words_q;
`ifdef LOAD_CHECKSUM_EN
    assign load_checksum    = checksum_q;
`endif

    always_comb begin
        state_d       = state_q;
        idle_cnt_d    = idle_cnt_q;
        cpu_reset_n_d = cpu_reset_n_q;
        overflow_d    = overflow_q;
        words_d       = words_q;
`ifdef LOAD_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif

        if (accept) begin
            if (words_q != 16'hFFFF) begin
                words_d = words_q + 16'd1;
            end
`ifdef LOAD_CHECKSUM_EN
            checksum_d = checksum_q + loader_word;
`endif
        end
        if (word_valid && in_load && !in_range) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            StWaitFirst: begin
                idle_cnt_d = '0;
                if (word_valid) begin
                    state_d = StLoading;
                end
            end
            StLoading: begin
                // A word arriving on the timeout cycle keeps the load open.
                if (word_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == CntLast) begin
                    idle_cnt_d = '0;
                    state_d    = StRun;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (reload_req) begin
                    state_d       = StWaitFirst;
                    cpu_reset_n_d = 1'b0;
                    words_d       = '0;
                    overflow_d    = 1'b0;
`ifdef LOAD_CHECKSUM_EN
                    checksum_d    = '0;
`endif
                end else begin
                    cpu_reset_n_d = 1'b1;
                end
            end
            default: begin
                state_d = StWaitFirst;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StWaitFirst;
            idle_cnt_q    <= '0;
            cpu_reset_n_q <= 1'b0;
            overflow_q    <= 1'b0;
            words_q       <= '0;
`ifdef LOAD_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            overflow_q    <= overflow_d;
            words_q       <= words_d;
`ifdef LOAD_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_program_load_controller.sv
// Directed bench for program_load_controller; memory writes are checked against a scoreboard queue.
module tb_program_load_controller;

    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam int unsigned MEM_BYTES      = 64;
    localparam int unsigned ADDR_W         = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              word_valid;
    logic [31:0]       loader_word;
    logic [ADDR_W-1:0] loader_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              reload_req;
    logic [ADDR_W-1:0] mem_byte_address;
    logic              mem_write_enable;
    logic [31:0]       mem_write_data;
    logic              cpu_reset_n;
    logic              loading;
    logic              overflow;
    logic [15:0]       words_loaded;
`ifdef LOAD_CHECKSUM_EN
    logic [31:0]       load_checksum;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    program_load_controller #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MEM_BYTES     (MEM_BYTES),
        .ADDR_W        (ADDR_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .word_valid      (word_valid),
        .loader_word     (loader_word),
        .loader_addr     (loader_addr),
        .fetch_addr      (fetch_addr),
        .reload_req      (reload_req),
        .mem_byte_address(mem_byte_address),
        .mem_write_enable(mem_write_enable),
        .mem_write_data  (mem_write_data),
        .cpu_reset_n     (cpu_reset_n),
        .loading         (loading),
        .overflow        (overflow),
        .words_loaded    (words_loaded)
`ifdef LOAD_CHECKSUM_EN
        ,
        .load_checksum   (load_checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset_n && mem_write_enable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", mem_byte_address, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", mem_byte_address, e[63:32]);
                check("write_data", mem_write_data, e[31:0]);
            end
        end
    end

    task automatic send_word(input logic [31:0] addr, input logic [31:0] data, input bit accepted);
        @(posedge clk);
        #1;
        word_valid  = 1'b1;
        loader_addr = addr;
        loader_word = data;
        if (accepted) exp_q.push_back({addr, data});
        @(posedge clk);
        #1;
        word_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        word_valid  = 1'b0;
        loader_word = '0;
        loader_addr = '0;
        fetch_addr  = '0;
        reload_req  = 1'b0;
        #12;
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("rst_loading", 32'(loading), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two words, then the idle timeout to RUN.
        send_word(32'h0, 32'h0040_0093, 1'b1);
        send_word(32'h4, 32'h0080_0113, 1'b1);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("t1_loading", 32'(loading), 32'd1);
`ifdef LOAD_CHECKSUM_EN
        check("t1_checksum", load_checksum, 32'h00C0_01A6);
`endif
        repeat (15) @(posedge clk);
        #1;
        check("t2_still_loading", 32'(loading), 32'd1);
        @(posedge clk);
        #1;
        fetch_addr = 32'h4;
        #1;
        check("t2_run_loading", 32'(loading), 32'd0);
        check("t2_fetch_mux", mem_byte_address, 32'h4);
        check("t2_cpu_still_reset", 32'(cpu_reset_n), 32'd0);
        @(posedge clk);
        #1;
        check("t2_cpu_released", 32'(cpu_reset_n), 32'd1);

        // Word in RUN is dropped, then reload.
        @(posedge clk);
        #1;
        word_valid  = 1'b1;
        loader_addr = 32'h8;
        loader_word = 32'hDEAD_BEEF;
        #1;
        check("t5_run_no_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        check("t5_run_words", 32'(words_loaded), 32'd2);
        reload_req = 1'b1;
        @(posedge clk);
        #1;
        reload_req = 1'b0;
        check("t5_reload_loading", 32'(loading), 32'd1);
        check("t5_reload_cpu", 32'(cpu_reset_n), 32'd0);
        check("t5_reload_words", 32'(words_loaded), 32'd0);
`ifdef LOAD_CHECKSUM_EN
        check("t5_reload_checksum", load_checksum, 32'd0);
`endif

        // Out-of-range word.
        @(posedge clk);
        #1;
        word_valid  = 1'b1;
        loader_addr = 32'h40;
        loader_word = 32'h1111_1111;
        #1;
        check("t4_oob_no_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_words", 32'(words_loaded), 32'd0);

        // Word arriving exactly at idle count 15 keeps the load open.
        send_word(32'h8, 32'h0030_0193, 1'b1);
        repeat (14) @(posedge clk);
        send_word(32'hC, 32'h0040_0213, 1'b1);
        check("t3_no_run", 32'(loading), 32'd1);
        check("t3_words", 32'(words_loaded), 32'd2);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        check("t3_still_loading", 32'(loading), 32'd1);
        @(posedge clk);
        #1;
        check("t3_run", 32'(loading), 32'd0);

        // Reload with a coincident word: word dropped, overflow cleared.
        @(posedge clk);
        #1;
        reload_req  = 1'b1;
        word_valid  = 1'b1;
        loader_addr = 32'h10;
        loader_word = 32'h2222_2222;
        #1;
        check("t5_coincident_no_we", 32'(mem_write_enable), 32'd0);
        @(posedge clk);
        #1;
        reload_req = 1'b0;
        word_valid = 1'b0;
        check("t5_ovf_cleared", 32'(overflow), 32'd0);
        check("t5_words_cleared", 32'(words_loaded), 32'd0);
        check("t5_waitfirst", 32'(loading), 32'd1);

        // Async reset in the middle of a load.
        send_word(32'h10, 32'h0050_0293, 1'b1);
        send_word(32'h80, 32'h3333_3333, 1'b0);
        check("t6_pre_words", 32'(words_loaded), 32'd1);
        check("t6_pre_overflow", 32'(overflow), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_words", 32'(words_loaded), 32'd0);
        check("t6_rst_overflow", 32'(overflow), 32'd0);
        check("t6_rst_loading", 32'(loading), 32'd1);
        check("t6_rst_cpu", 32'(cpu_reset_n), 32'd0);
`ifdef LOAD_CHECKSUM_EN
        check("t6_rst_checksum", load_checksum, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
